io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Buffered RS-232 transmitter that acts as a responder on the TinyComp IO bus: a CPU IO write to its device address queues one byte.
- The block serializes queued bytes as 8N1 frames on TxD.
- It returns a "space available" status that the CPU polls through the InReady skip path (Ski/Skni).
- It sits beside the existing rs232 block and allows multi-byte bursts without per-byte polling.

Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DEPTH, 16, FIFO entries; power of two, 2..256.
- DEV_ADDR, 3, 4-bit IO device address this block answers to.

Ports:
- Clock  in  1  board clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- ioStrobe  in  1  IO opcode active this cycle.
- ioWrite  in  1  1 = IO write (Rb[0]); 0 = IO read.
- ioAddr  in  4  IO device address (Rb[4:1]).
- ioWData  in  8  byte to transmit (RFAout[7:0]).
- txSpace  out  1  FIFO not full; the CPU ORs this into InReady when reading DEV_ADDR.
- txIdle  out  1  FIFO empty and serializer in IDLE.
- TxD  out  1  serial output, idle high.

Behaviour:
- Interface: one clock (Clock); Reset is synchronous and active-high. Reset dominates every other input in the same cycle.
- Reset values and effect:
  - TxD=1, txSpace=1, txIdle=1.
  - FIFO pointers and count cleared; FSM=IDLE; baud and bit counters cleared.
  - Reset mid-frame truncates the frame, and TxD is 1 on the following cycle.
- Push:
  - Condition: ioStrobe & ioWrite & ioAddr==DEV_ADDR & txSpace, sampled at posedge.
  - Writes ioWData to the FIFO and increments count.
  - A write while full (txSpace=0) is dropped silently.
  - Full is judged on the pre-edge count, so a push while full is dropped even if a pop occurs the same cycle.
  - Writes to other addresses, and reads, never affect state.
- FIFO:
  - Circular, ptr width log2(DEPTH); pointers wrap from DEPTH-1 to 0.
  - Count width is log2(DEPTH)+1.
  - A simultaneous push and pop when not full and not empty leaves count unchanged.
  - txSpace = (count != DEPTH); combinational from registered count.
- Baud timing:
  - DIV = (CLK_HZ + BAUD/2) / BAUD, which is 434 for the defaults.
  - Each bit is held exactly DIV cycles.
  - The baud counter is reloaded at the start of every bit, so there is no accumulated drift across a frame.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the shift register, set TxD=0 at the same edge, go to START.
  - START: hold for DIV cycles, then go to DATA with bitcnt=0 and TxD=shift[0].
  - DATA: every DIV cycles, shift right and increment bitcnt. After bit 7 has been held DIV cycles, go to STOP with TxD=1.
  - STOP: hold DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (TxD=0, back-to-back frames with no idle gap); otherwise go to IDLE.
- Latency:
  - A push accepted at edge N causes TxD to fall at edge N+1 when the FSM is IDLE.
  - Each frame lasts exactly 10*DIV cycles; LSB is sent first.
- txIdle = (count==0) & (state==IDLE).
- TxD is driven from a flop (glitch-free).

Optional Feature:
- Macro: IO_UART_TX_OVERFLOW_EN.
- When defined:
  - Adds output port txOverflow (1 bit), reset 0.
  - txOverflow is set sticky on any dropped push (the address-matched write while full).
  - It is cleared by an IO read (ioStrobe & ~ioWrite) to DEV_ADDR, one cycle after the read.
  - Set has priority over clear in the same cycle.
- When undefined: the port is absent and dropped writes leave no trace.

Decomposition:
- Shared package io_uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Function baud_div(clk_hz, baud).
  - Constants FRAME_BITS=10 and DATA_BITS=8.
  - Localparam helpers for log2 widths.
- Sub-module sync_fifo, parameterized by WIDTH and DEPTH:
  - Ports: push, pop, wdata, rdata (head, first-word-fall-through), full, empty, count.
  - It is reusable for a future RX buffer.
- The top level holds address decode, baud counter and FSM.

Test Plan:
- Reset then idle 1000 cycles -> TxD=1, txSpace=1, txIdle=1 throughout.
- Single write of 0xA5 to addr 3 -> TxD falls 1 cycle later. Bits sampled at mid-bit (DIV/2 offsets) read 0,1,0,1,0,0,1,0,1 then stop=1. The frame is 4340 cycles, and txIdle=1 after it.
- Burst of 3 bytes 0x01, 0x02, 0x03 on consecutive cycles -> three frames back-to-back, no idle gap between stop and next start; total 13020 cycles.
- Push 17 bytes with DEPTH=16 while the first frame is in START:
  - the first pop frees one slot, so all 17 are accepted;
  - an 18th write while txSpace=0 is dropped;
  - the decoded output equals the first 17 bytes in order;
  - txOverflow=1 with the macro defined, and it clears after an IO read to addr 3.
- Writes to addr 2, and a read to addr 3 with ioWrite=0 -> no FIFO change, TxD stays 1.
- Reset asserted at cycle 2000 of a frame -> TxD=1 next cycle, FIFO empty, txSpace=1. A new write afterwards produces a clean full frame.

Source files
------------

// File: rtl/io_uart_pkg.sv
// Shared types and helpers for the TinyComp IO-bus UART blocks.
package io_uart_pkg;

    localparam int FRAME_BITS = 10;  // start + 8 data + stop
    localparam int DATA_BITS  = 8;

    // Serializer state; explicit encoding keeps it stable across tools.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // One IO bus transaction as seen by a responder.
    typedef struct packed {
        logic       strobe;
        logic       write;
        logic [3:0] addr;
        logic [7:0] wdata;
    } io_req_t;

    // Clocks per serial bit, rounded to nearest.
    function automatic int baud_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud / 2) / baud);
    endfunction

    // Bits needed to index n distinct values (at least 1).
    function automatic int ctr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed for an occupancy count 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Circular synchronous FIFO, first-word-fall-through head on rdata.
// Push while full and pop while empty are ignored, so callers may leave them ungated.
module sync_fifo
    import io_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = ctr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Full/empty come from the registered count, i.e. the pre-edge occupancy.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Buffered 8N1 transmitter answering IO writes to DEV_ADDR.
// Optional sticky overflow flag: define IO_UART_TX_OVERFLOW_EN to add txOverflow.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int         CLK_HZ   = 50000000,
    parameter int         BAUD     = 115200,
    parameter int         DEPTH    = 16,
    parameter logic [3:0] DEV_ADDR = 4'd3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ioStrobe,
    input  logic       ioWrite,
    input  logic [3:0] ioAddr,
    input  logic [7:0] ioWData,
    output logic       txSpace,
    output logic       txIdle,
    output logic       TxD
`ifdef IO_UART_TX_OVERFLOW_EN
    ,
    output logic       txOverflow
`endif
);

    localparam int                DIV      = baud_div(CLK_HZ, BAUD);
    localparam int                BAUD_W   = ctr_w(DIV);
    localparam int                CNT_W    = cnt_w(DEPTH);
    localparam logic [BAUD_W-1:0] DIV_LAST = BAUD_W'(DIV - 1);

    io_req_t                req;
    logic                   wr_hit, rd_hit;
    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;
    logic [CNT_W-1:0]       fifo_count;

    uart_state_e            state;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   bit_done;

    assign req    = io_req_t'{ioStrobe, ioWrite, ioAddr, ioWData};
    assign wr_hit = req.strobe & req.write & (req.addr == DEV_ADDR);
    assign rd_hit = req.strobe & ~req.write & (req.addr == DEV_ADDR);

    assign txSpace  = ~fifo_full;
    assign txIdle   = (fifo_count == '0) & (state == IDLE);
    assign bit_done = (baud_cnt == DIV_LAST);

    // A new frame starts from IDLE, or straight out of STOP for gapless bursts.
    assign fifo_pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (wr_hit),
        .pop   (fifo_pop),
        .wdata (req.wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serializer: baud counter restarts on every bit so a frame never drifts.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            TxD      <= 1'b1;
        end else begin
            baud_cnt <= ((state == IDLE) || bit_done) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift <= fifo_head;
                        TxD   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        TxD     <= shift[0];
                        shift   <= {1'b0, shift[DATA_BITS-1:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            TxD   <= 1'b1;
                            state <= STOP;
                        end else begin
                            TxD     <= shift[0];
                            shift   <= {1'b0, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (!fifo_empty) begin
                            shift <= fifo_head;
                            TxD   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IO_UART_TX_OVERFLOW_EN
    // Sticky record of a dropped write; a status read clears it, a new drop wins.
    always_ff @(posedge Clock) begin
        if (Reset)                   txOverflow <= 1'b0;
        else if (wr_hit & fifo_full) txOverflow <= 1'b1;
        else if (rd_hit)             txOverflow <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomized scoreboard bench for io_uart_tx. A timeline model predicts which
// writes are accepted, when each frame starts and what byte it carries; a
// negedge monitor decodes TxD at mid-bit and compares against the queues.
module tb_io_uart_tx;

    localparam int         CLK_HZ   = 1250000;
    localparam int         BAUD     = 100000;
    localparam int         DEPTH    = 16;
    localparam logic [3:0] DEV      = 4'd3;
    localparam int         DIV      = (CLK_HZ + BAUD / 2) / BAUD;  // 13
    localparam int         FRAME    = 10 * DIV;

    logic       Clock = 1'b0;
    logic       Reset, ioStrobe, ioWrite;
    logic [3:0] ioAddr;
    logic [7:0] ioWData;
    logic       txSpace, txIdle, TxD;
`ifdef IO_UART_TX_OVERFLOW_EN
    logic       txOverflow;
`endif

    io_uart_tx #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH),
        .DEV_ADDR (DEV)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ioStrobe (ioStrobe),
        .ioWrite  (ioWrite),
        .ioAddr   (ioAddr),
        .ioWData  (ioWData),
        .txSpace  (txSpace),
        .txIdle   (txIdle),
        .TxD      (TxD)
`ifdef IO_UART_TX_OVERFLOW_EN
        ,
        .txOverflow (txOverflow)
`endif
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (timeline level) ----------------
    int         cyc       = 0;
    bit         started   = 0;
    bit         abort     = 0;
    int         m_cnt     = 0;   // bytes waiting in the buffer
    int         m_free_at = 0;   // first edge at which the line can start a new frame
    bit         m_ovf     = 0;
    logic [7:0] exp_q[$];        // bytes in transmit order
    int         exp_start[$];    // edge at which each frame's start bit begins

    initial forever begin
        @(posedge Clock);
        cyc++;
        started = 1;
        if (Reset) begin
            m_cnt     = 0;
            m_free_at = 0;
            m_ovf     = 0;
            exp_q.delete();
            exp_start.delete();
            abort     = 1;
        end else begin
            automatic bit hit  = ioStrobe && (ioAddr == DEV);
            automatic bit wr   = hit && ioWrite;
            automatic bit push = wr && (m_cnt != DEPTH);
            automatic bit pop  = (m_cnt > 0) && (cyc >= m_free_at);
            if (wr && m_cnt == DEPTH) m_ovf = 1;
            else if (hit && !ioWrite) m_ovf = 0;
            if (pop) begin
                exp_start.push_back(cyc);
                m_free_at = cyc + FRAME;
            end
            if (push) exp_q.push_back(ioWData);
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    end

    // ---------------- monitor / frame decoder ----------------
    bit         busy = 0;
    int         t0, k;
    logic [7:0] bits;

    initial forever begin
        @(negedge Clock);
        if (started) begin
            if (abort) begin
                abort = 0;
                busy  = 0;
                chk("txd_after_reset", TxD, 1'b1);
            end
            chk("txSpace", txSpace, (m_cnt != DEPTH));
            chk("txIdle", txIdle, (m_cnt == 0) && (cyc >= m_free_at));
`ifdef IO_UART_TX_OVERFLOW_EN
            chk("txOverflow", txOverflow, m_ovf);
`endif
            if (!busy) begin
                if (exp_start.size() == 0 || cyc < exp_start[0]) begin
                    chk("txd_idle_high", TxD, 1'b1);
                end else begin
                    automatic int t = exp_start.pop_front();
                    chk("start_edge_txd", TxD, 1'b0);
                    chk("start_cycle", cyc, t);
                    busy = 1;
                    t0   = t;
                    k    = 0;
                end
            end else if (cyc == t0 + k * DIV + DIV / 2) begin
                if (k == 0) chk("start_bit", TxD, 1'b0);
                else if (k <= 8) bits[k-1] = TxD;
                else begin
                    chk("stop_bit", TxD, 1'b1);
                    if (exp_q.size() > 0) chk("data_byte", bits, exp_q.pop_front());
                    busy = 0;
                end
                k++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic io_cycle(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        ioStrobe = s; ioWrite = w; ioAddr = a; ioWData = d;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) io_cycle(1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_cnt != 0 || cyc < m_free_at) && n < 40000) begin
            idle(1);
            n++;
        end
        chk("drain_in_budget", (n < 40000), 1'b1);
        idle(2);
        chk("txIdle_after_drain", txIdle, 1'b1);
        chk("txd_after_drain", TxD, 1'b1);
    endtask

    initial begin
        Reset = 1'b1; ioStrobe = 1'b0; ioWrite = 1'b0; ioAddr = 4'd0; ioWData = 8'd0;
        idle(2);
        chk("reset_txd", TxD, 1'b1);
        chk("reset_txSpace", txSpace, 1'b1);
        chk("reset_txIdle", txIdle, 1'b1);
        Reset = 1'b0;
        idle(1000);

        // single frame
        io_cycle(1'b1, 1'b1, DEV, 8'hA5);
        chk("txd_falls_next_edge", TxD, 1'b1);
        idle(1);
        chk("txd_low_after_one", TxD, 1'b0);
        drain();

        // gapless burst
        io_cycle(1'b1, 1'b1, DEV, 8'h01);
        io_cycle(1'b1, 1'b1, DEV, 8'h02);
        io_cycle(1'b1, 1'b1, DEV, 8'h03);
        drain();

        // fill: 17 accepted, 18th dropped
        for (int i = 0; i < 17; i++) io_cycle(1'b1, 1'b1, DEV, 8'($urandom));
        chk("full_txSpace", txSpace, 1'b0);
        io_cycle(1'b1, 1'b1, DEV, 8'hEE);
        chk("dropped_txSpace", txSpace, 1'b0);
`ifdef IO_UART_TX_OVERFLOW_EN
        chk("ovf_set", txOverflow, 1'b1);
        io_cycle(1'b1, 1'b0, DEV, 8'h00);
        chk("ovf_cleared", txOverflow, 1'b0);
`endif
        drain();

        // other address writes and reads of DEV_ADDR change nothing
        io_cycle(1'b1, 1'b1, 4'd2, 8'h55);
        io_cycle(1'b1, 1'b1, 4'd2, 8'hAA);
        io_cycle(1'b1, 1'b0, DEV, 8'h77);
        idle(3 * DIV);
        chk("misc_txd", TxD, 1'b1);
        chk("misc_txIdle", txIdle, 1'b1);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            automatic int r = $urandom_range(0, 9);
            if (r < 6)       io_cycle(1'b1, 1'b1, DEV, 8'($urandom));
            else if (r == 6) io_cycle(1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
            else if (r == 7) io_cycle(1'b1, 1'b0, DEV, 8'($urandom));
            else             io_cycle(1'b0, 1'b1, DEV, 8'($urandom));
            if ($urandom_range(0, 3) != 0) idle($urandom_range(0, 30));
        end
        drain();

        // reset mid-frame, then a clean frame
        io_cycle(1'b1, 1'b1, DEV, 8'h3C);
        io_cycle(1'b1, 1'b1, DEV, 8'hC3);
        idle(5 * DIV);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        chk("midreset_txd", TxD, 1'b1);
        chk("midreset_txSpace", txSpace, 1'b1);
        chk("midreset_txIdle", txIdle, 1'b1);
        idle(4);
        io_cycle(1'b1, 1'b1, DEV, 8'h96);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
